usb_dbg_bridge: RTL

- Core-side endpoint of the USB-CDC byte stream. It consumes host bytes from the CDC rx channel and produces response bytes on the CDC tx channel.
- Host frames are decoded into single-word memory-bus reads and writes, and the block returns an ACK/NAK byte or the read data.
- Sits between the usbcdc instance and the core memory bus as a debug/monitor port; it is the responder to the host initiator.

---
 rtl/dbg_pkg.sv | 17 +
 rtl/dbg_timeout_ctr.sv | 39 +++
 rtl/usb_dbg_bridge.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared command/response codes and FSM state encoding for the USB debug bridge.
package dbg_pkg;

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        BUS,
        RESP
    } dbg_state_t;

endpackage

// File: rtl/dbg_timeout_ctr.sv
// Saturating down-counter timeout: clr reloads LIMIT-1, en counts down to zero.
// expired is high while enabled and the count has reached zero.
module dbg_timeout_ctr #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk48,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LOAD = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload on clear, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/usb_dbg_bridge.sv
// USB-CDC debug bridge: decodes host 'R'/'W' frames into single-word bus
// accesses and returns ACK/NAK or the read word (little-endian).
//
// state | meaning
// IDLE  | waiting for a command byte
// ADDR  | collecting 4 address bytes
// WDATA | collecting 4 write-data bytes
// BUS   | mem_req outstanding, waiting for mem_ack or bus timeout
// RESP  | sending 1 or 4 response bytes
module usb_dbg_bridge
    import dbg_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned IDLE_TIMEOUT = 48000000,
    parameter int unsigned BUS_TIMEOUT  = 1024
) (
    input  logic              clk48,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    dbg_state_t  state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] resp_q, resp_d;
    logic [1:0]  resp_last_q, resp_last_d;
    logic [1:0]  tx_cnt_q, tx_cnt_d;
    logic        rx_ready_q, rx_ready_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        mem_req_q, mem_req_d;

    logic rx_fire, tx_fire, ack_fire;
    logic idle_en, idle_clr, idle_exp;
    logic bus_en, bus_clr, bus_exp;

    assign rx_fire  = rx_valid && rx_ready_q;
    assign tx_fire  = tx_valid_q && tx_ready;
    // An ack before mem_req is visible (entry cycle) or after timeout is ignored.
    assign ack_fire = mem_req_q && mem_ack;

    assign idle_en  = (state_q == ADDR) || (state_q == WDATA);
    assign idle_clr = rx_fire || !idle_en;
    assign bus_en   = (state_q == BUS);
    assign bus_clr  = !bus_en;

    dbg_timeout_ctr #(.LIMIT(IDLE_TIMEOUT)) u_idle_tmr (
        .clk48   (clk48),
        .reset   (reset),
        .clr     (idle_clr),
        .en      (idle_en),
        .expired (idle_exp)
    );

    dbg_timeout_ctr #(.LIMIT(BUS_TIMEOUT)) u_bus_tmr (
        .clk48   (clk48),
        .reset   (reset),
        .clr     (bus_clr),
        .en      (bus_en),
        .expired (bus_exp)
    );

    // Next-state, frame assembly and registered-output decode.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_d      = resp_q;
        resp_last_d = resp_last_q;
        tx_cnt_d    = tx_cnt_q;

        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    byte_cnt_d = 2'd0;
                    if (rx_data == CMD_READ) begin
                        we_d    = 1'b0;
                        state_d = ADDR;
                    end else if (rx_data == CMD_WRITE) begin
                        we_d    = 1'b1;
                        state_d = ADDR;
                    end else begin
                        resp_d      = {24'h0, RSP_NAK};
                        resp_last_d = 2'd0;
                        tx_cnt_d    = 2'd0;
                        state_d     = RESP;
                    end
                end
            end
            ADDR: begin
                // A byte in the expiry cycle takes priority over the timeout.
                if (rx_fire) begin
                    addr_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = we_q ? WDATA : BUS;
                    end
                end else if (idle_exp) begin
                    byte_cnt_d = 2'd0;
                    state_d    = IDLE;
                end
            end
            WDATA: begin
                if (rx_fire) begin
                    wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = BUS;
                    end
                end else if (idle_exp) begin
                    byte_cnt_d = 2'd0;
                    state_d    = IDLE;
                end
            end
            BUS: begin
                // Ack in the expiry cycle completes the transaction normally.
                if (ack_fire) begin
                    if (we_q) begin
                        resp_d      = {24'h0, RSP_ACK};
                        resp_last_d = 2'd0;
                    end else begin
                        resp_d      = mem_rdata;
                        resp_last_d = 2'd3;
                    end
                    tx_cnt_d = 2'd0;
                    state_d  = RESP;
                end else if (bus_exp) begin
                    resp_d      = {24'h0, RSP_NAK};
                    resp_last_d = 2'd0;
                    tx_cnt_d    = 2'd0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (tx_fire) begin
                    if (tx_cnt_q == resp_last_q) begin
                        tx_cnt_d = 2'd0;
                        state_d  = IDLE;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rx_ready_d = (state_d == IDLE) || (state_d == ADDR) || (state_d == WDATA);
        tx_valid_d = (state_d == RESP);
        tx_data_d  = resp_d[{tx_cnt_d, 3'b000} +: 8];
        mem_req_d  = (state_q == BUS) && (state_d == BUS);
    end

    // State and output registers; reset drops every handshake at once.
    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 2'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            resp_q      <= 32'h0;
            resp_last_q <= 2'd0;
            tx_cnt_q    <= 2'd0;
            rx_ready_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h0;
            mem_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_q      <= resp_d;
            resp_last_q <= resp_last_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_ready_q  <= rx_ready_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            mem_req_q   <= mem_req_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q[ADDR_W-1:0];
    assign mem_wdata = wdata_q;

endmodule
